// File: rtl/alu_issue_stage_pkg.sv
// Shared ISA definitions for the 19-bit CPU: widths, instruction field positions,
// opcode encoding and decode helpers used by the issue stage and its scoreboard.
package alu_issue_stage_pkg;

  localparam int DW    = 19;
  localparam int NREG  = 8;
  localparam int RW    = 3;
  localparam int OPW   = 5;
  localparam int IMM_W = 11;

  localparam int OP_LSB  = 14;
  localparam int RD_LSB  = 11;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 5;

  typedef enum logic [OPW-1:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_MUL   = 5'd2,
    OP_DIV   = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_XOR   = 5'd6,
    OP_NOT   = 5'd7,
    OP_ENCRY = 5'd8,
    OP_DECRY = 5'd9,
    OP_IMMED = 5'd10
  } opcode_e;

  typedef struct packed {
    logic [OPW-1:0] ctrl;
    logic [DW-1:0]  in1;
    logic [DW-1:0]  in2;
    logic [RW-1:0]  rd;
  } issue_pkt_t;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return op <= OP_IMMED;
  endfunction

  function automatic logic uses_rs1(input logic [OPW-1:0] op);
    return is_legal(op) && (op != OP_IMMED);
  endfunction

  // Two-source ops are exactly the contiguous block ADD..XOR.
  function automatic logic uses_rs2(input logic [OPW-1:0] op);
    return op <= OP_XOR;
  endfunction

  function automatic logic [DW-1:0] zext_imm(input logic [DW-1:0] instr);
    return {{(DW-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-packet channel from the decode/issue stage to the EX stage (valid/ready).
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic           ex_valid;
  logic           ex_ready;
  logic [OPW-1:0] alu_ctrl;
  logic [DW-1:0]  in1;
  logic [DW-1:0]  in2;
  logic [RW-1:0]  ex_rd;

  modport master (output ex_valid, alu_ctrl, in1, in2, ex_rd, input ex_ready);
  modport slave  (input ex_valid, alu_ctrl, in1, in2, ex_rd, output ex_ready);

endinterface

// File: rtl/alu_issue_stage_scoreboard.sv
// Busy-bit scoreboard for in-flight destinations; answers the RAW hazard query
// for the instruction currently being decoded.
module alu_issue_stage_scoreboard
  import alu_issue_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic          flush_en,
  input  logic [RW-1:0] flush_idx,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use1,
  input  logic          use2,
  output logic          hazard
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Set is applied last so a new producer wins over a retiring one on the same register.
  always_comb begin
    busy_nxt = busy;
    if (clr_en)   busy_nxt[clr_idx]   = 1'b0;
    if (flush_en) busy_nxt[flush_idx] = 1'b0;
    if (set_en)   busy_nxt[set_idx]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // A same-cycle writeback to the source supplies the value through the bypass.
  always_comb begin
    hazard = (use1 && busy[rs1] && !(clr_en && (clr_idx == rs1))) ||
             (use2 && busy[rs2] && !(clr_en && (clr_idx == rs2)));
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes the fetched word, selects operands (register file or
// writeback bypass), stalls on RAW hazards and registers one issue packet for EX.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DW-1:0]     if_instr,
  output logic              if_ready,
  output logic [RW-1:0]     rf_rs1_addr,
  output logic [RW-1:0]     rf_rs2_addr,
  input  logic [DW-1:0]     rf_rs1_data,
  input  logic [DW-1:0]     rf_rs2_data,
  input  logic              wb_valid,
  input  logic [RW-1:0]     wb_rd,
  input  logic [DW-1:0]     wb_data,
  input  logic              flush,
  alu_issue_stage_if.master ex,
  output logic              illegal_op
);

  logic [OPW-1:0] op_p0;
  logic [RW-1:0]  rd_p0;
  logic           legal_p0;
  logic           use1_p0;
  logic           use2_p0;
  logic           byp1_p0;
  logic           byp2_p0;
  logic           hazard_p0;
  logic           out_free;
  logic           accept;
  issue_pkt_t     pkt_p0;

  issue_pkt_t     pkt_p1;
  logic           vld_p1;
  logic           ill_p1;

  // ---- p0: decode, operand select, hazard check ----
  assign op_p0       = if_instr[OP_LSB+OPW-1:OP_LSB];
  assign rd_p0       = if_instr[RD_LSB+RW-1:RD_LSB];
  assign rf_rs1_addr = if_instr[RS1_LSB+RW-1:RS1_LSB];
  assign rf_rs2_addr = if_instr[RS2_LSB+RW-1:RS2_LSB];

  assign legal_p0 = is_legal(op_p0);
  assign use1_p0  = uses_rs1(op_p0);
  assign use2_p0  = uses_rs2(op_p0);
  assign byp1_p0  = wb_valid && (wb_rd == rf_rs1_addr);
  assign byp2_p0  = wb_valid && (wb_rd == rf_rs2_addr);

  always_comb begin
    pkt_p0.ctrl = op_p0;
    pkt_p0.rd   = rd_p0;
    pkt_p0.in1  = byp1_p0 ? wb_data : rf_rs1_data;
    if (op_p0 == OP_IMMED) pkt_p0.in2 = zext_imm(if_instr);
    else                   pkt_p0.in2 = byp2_p0 ? wb_data : rf_rs2_data;
  end

  assign out_free = !vld_p1 || ex.ex_ready;
  assign if_ready = out_free && !hazard_p0 && !flush;
  assign accept   = if_valid && if_ready;

  alu_issue_stage_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && legal_p0),
    .set_idx  (rd_p0),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .flush_en (flush && vld_p1),
    .flush_idx(pkt_p1.rd),
    .rs1      (rf_rs1_addr),
    .rs2      (rf_rs2_addr),
    .use1     (use1_p0),
    .use2     (use2_p0),
    .hazard   (hazard_p0)
  );

  // ---- p1: issue register toward EX ----
  // Illegal words are consumed but leave a bubble; the payload only moves on a legal accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      pkt_p1 <= '0;
    end else begin
      ill_p1 <= accept && !legal_p0;
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (out_free) begin
        vld_p1 <= accept && legal_p0;
        if (accept && legal_p0) pkt_p1 <= pkt_p0;
      end
    end
  end

  assign ex.ex_valid = vld_p1;
  assign ex.alu_ctrl = pkt_p1.ctrl;
  assign ex.in1      = pkt_p1.in1;
  assign ex.in2      = pkt_p1.in2;
  assign ex.ex_rd    = pkt_p1.rd;
  assign illegal_op  = ill_p1;

endmodule
